// File: rtl/bullet_fire_controller_if.sv
// Button, game-state and bullet-slot signals shared by the fire controller and
// the 32 bullet slots.
interface bullet_fire_controller_if;
    logic        _fireButton;
    logic        gameActive;
    logic [31:0] bulletBusy;
    logic        _isBulletFire;
    logic [4:0]  shootingBulletID;
    logic        noFreeSlot;
    logic [7:0]  shotCount;

    modport master (
        output _fireButton,
        output gameActive,
        output bulletBusy,
        input  _isBulletFire,
        input  shootingBulletID,
        input  noFreeSlot,
        input  shotCount
    );

    modport slave (
        input  _fireButton,
        input  gameActive,
        input  bulletBusy,
        output _isBulletFire,
        output shootingBulletID,
        output noFreeSlot,
        output shotCount
    );
endinterface

// File: rtl/bullet_fire_controller.sv
// Debounced fire button to single-shot launcher: picks the next free bullet slot
// round-robin, strobes it for one frame, then enforces a cooldown and a release.
module bullet_fire_controller #(
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic                     frameClk,
    input  logic                     reset,
    bullet_fire_controller_if.slave  bus
);

    // state    | meaning
    // IDLE     | waiting for a synchronized press
    // DEBOUNCE | counting consecutive pressed frames
    // SELECT   | one frame: search for a free slot from rr_ptr_q
    // FIRE     | one frame: strobe low, advance pointer and shot count
    // COOLDOWN | fixed frame delay, button ignored
    // HOLD     | wait for release so one press gives one shot
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DEBOUNCE = 3'd1,
        SELECT   = 3'd2,
        FIRE     = 3'd3,
        COOLDOWN = 3'd4,
        HOLD     = 3'd5
    } state_t;

    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_FRAMES - 1);
    localparam logic [7:0] CD_LAST = 8'(COOLDOWN_FRAMES - 1);

    state_t      state_q, state_d;
    logic [3:0]  dbc_q, dbc_d;
    logic [7:0]  cdc_q, cdc_d;
    logic [4:0]  rr_ptr_q, rr_ptr_d;
    logic [4:0]  slot_id_q, slot_id_d;
    logic [7:0]  shot_cnt_q, shot_cnt_d;
    logic        sync1_q, sync2_q;

    logic        pressed;
    logic [62:0] busy_dbl;
    logic [31:0] busy_rot;
    logic        slot_found;
    logic [4:0]  slot_off;
    logic [4:0]  free_id;
    logic        fire_n;
    logic        no_free;

    assign pressed = ~sync2_q;

    // Doubling the busy vector turns the modulo-32 search into a plain rotate.
    assign busy_dbl = {bus.bulletBusy[30:0], bus.bulletBusy};
    assign busy_rot = busy_dbl[rr_ptr_q +: 32];

    always_comb begin
        slot_found = 1'b0;
        slot_off   = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (!busy_rot[i]) begin
                slot_found = 1'b1;
                slot_off   = 5'(i);
            end
        end
    end

    assign free_id = rr_ptr_q + slot_off;

    always_ff @(posedge frameClk) begin
        if (reset) begin
            state_q    <= IDLE;
            dbc_q      <= 4'd0;
            cdc_q      <= 8'd0;
            rr_ptr_q   <= 5'd0;
            slot_id_q  <= 5'd0;
            shot_cnt_q <= 8'd0;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            dbc_q      <= dbc_d;
            cdc_q      <= cdc_d;
            rr_ptr_q   <= rr_ptr_d;
            slot_id_q  <= slot_id_d;
            shot_cnt_q <= shot_cnt_d;
            sync1_q    <= bus._fireButton;
            sync2_q    <= sync1_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        dbc_d      = dbc_q;
        cdc_d      = cdc_q;
        rr_ptr_d   = rr_ptr_q;
        slot_id_d  = slot_id_q;
        shot_cnt_d = shot_cnt_q;
        if (!bus.gameActive) begin
            // Pointer, last ID and shot count survive a pause; a pending shot does not.
            state_d = IDLE;
            dbc_d   = 4'd0;
            cdc_d   = 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pressed) begin
                        state_d = DEBOUNCE;
                        dbc_d   = 4'd1;
                    end
                end
                DEBOUNCE: begin
                    if (!pressed) begin
                        state_d = IDLE;
                        dbc_d   = 4'd0;
                    end else if (dbc_q == DB_LAST) begin
                        state_d = SELECT;
                        dbc_d   = 4'd0;
                    end else begin
                        dbc_d = dbc_q + 4'd1;
                    end
                end
                SELECT: begin
                    if (slot_found) begin
                        slot_id_d = free_id;
                        state_d   = FIRE;
                    end else begin
                        state_d = HOLD;
                    end
                end
                FIRE: begin
                    rr_ptr_d   = slot_id_q + 5'd1;
                    shot_cnt_d = (shot_cnt_q == 8'hFF) ? shot_cnt_q : shot_cnt_q + 8'd1;
                    cdc_d      = 8'd0;
                    state_d    = COOLDOWN;
                end
                COOLDOWN: begin
                    if (cdc_q == CD_LAST) begin
                        state_d = HOLD;
                        cdc_d   = 8'd0;
                    end else begin
                        cdc_d = cdc_q + 8'd1;
                    end
                end
                HOLD: begin
                    if (!pressed) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    dbc_d   = 4'd0;
                    cdc_d   = 8'd0;
                end
            endcase
        end
    end

    always_comb begin
        fire_n  = (state_q != FIRE);
        no_free = (state_q == SELECT) && bus.gameActive && !slot_found;
    end

    assign bus._isBulletFire    = fire_n;
    assign bus.shootingBulletID = slot_id_q;
    assign bus.noFreeSlot       = no_free;
    assign bus.shotCount        = shot_cnt_q;

endmodule

// File: tb/tb_bullet_fire_controller.sv
// Bench for bullet_fire_controller: directed scenarios plus random stimulus,
// all outputs compared every frame against an event-level model.
module tb_bullet_fire_controller;

    localparam int DB = 3;
    localparam int CD = 8;

    logic frameClk = 1'b0;
    logic reset;

    bullet_fire_controller_if bus_if ();

    bullet_fire_controller #(
        .DEBOUNCE_FRAMES(DB),
        .COOLDOWN_FRAMES(CD)
    ) dut (
        .frameClk (frameClk),
        .reset    (reset),
        .bus      (bus_if)
    );

    always #5 frameClk = ~frameClk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Event-level model: press length, pending select/fire, frames of cooldown left,
    // waiting-for-release flag.
    logic m_s1, m_s2;
    bit   m_p, m_sel, m_fire, m_hold, m_ok, m_found;
    int   m_run, m_cool, m_rr, m_id, m_cnt;
    int   cyc = 0;

    initial m_ok = 1'b0;

    always @(posedge frameClk) begin
        cyc++;
        m_p = (m_s2 == 1'b0);
        if (reset) begin
            m_s1 = 1'b1; m_s2 = 1'b1;
            m_run = 0; m_cool = 0; m_sel = 0; m_fire = 0; m_hold = 0;
            m_rr = 0; m_id = 0; m_cnt = 0;
            m_ok = 1'b1;
        end else begin
            m_s2 = m_s1;
            m_s1 = bus_if._fireButton;
            if (!bus_if.gameActive) begin
                m_run = 0; m_cool = 0; m_sel = 0; m_fire = 0; m_hold = 0;
            end else if (m_fire) begin
                m_fire = 0;
                m_rr   = (m_id + 1) % 32;
                if (m_cnt < 255) m_cnt++;
                m_cool = CD;
            end else if (m_sel) begin
                m_sel   = 0;
                m_found = 0;
                for (int k = 0; k < 32; k++) begin
                    if (!m_found && !bus_if.bulletBusy[(m_rr + k) % 32]) begin
                        m_found = 1;
                        m_id    = (m_rr + k) % 32;
                    end
                end
                if (m_found) m_fire = 1;
                else         m_hold = 1;
            end else if (m_cool > 0) begin
                m_cool--;
                if (m_cool == 0) m_hold = 1;
            end else if (m_hold) begin
                if (!m_p) m_hold = 0;
            end else if (m_run > 0) begin
                if (!m_p)                m_run = 0;
                else if (m_run == DB - 1) begin
                    m_run = 0;
                    m_sel = 1;
                end else                 m_run++;
            end else if (m_p) begin
                m_run = 1;
            end
        end
    end

    int n_strobe = 0;
    int n_nofree = 0;
    int last_fire_cyc = -1000;
    int fire_gap = 0;

    always @(negedge frameClk) begin
        if (m_ok) begin
            chk("strobe", int'(bus_if._isBulletFire), int'(!m_fire));
            chk("slot_id", int'(bus_if.shootingBulletID), m_id);
            chk("no_free", int'(bus_if.noFreeSlot),
                int'(m_sel && bus_if.gameActive && (bus_if.bulletBusy == 32'hFFFF_FFFF)));
            chk("shot_count", int'(bus_if.shotCount), m_cnt);
        end
        if (bus_if._isBulletFire === 1'b0) begin
            n_strobe++;
            fire_gap      = cyc - last_fire_cyc;
            last_fire_cyc = cyc;
        end
        if (bus_if.noFreeSlot === 1'b1) n_nofree++;
    end

    task automatic tick();
        @(posedge frameClk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus_if._fireButton = 1'b1;
        bus_if.gameActive  = 1'b1;
        bus_if.bulletBusy  = 32'h0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic press();
        bus_if._fireButton = 1'b0;
        repeat (8) tick();
        bus_if._fireButton = 1'b1;
        repeat (16) tick();
    endtask

    int s0, f0, first, lows;
    bit seen;

    initial begin
        reset = 1'b1;
        bus_if._fireButton = 1'b1;
        bus_if.gameActive  = 1'b1;
        bus_if.bulletBusy  = 32'h0;
        tick();
        tick();
        chk("rst_strobe", int'(bus_if._isBulletFire), 1);
        chk("rst_id", int'(bus_if.shootingBulletID), 0);
        chk("rst_nofree", int'(bus_if.noFreeSlot), 0);
        chk("rst_count", int'(bus_if.shotCount), 0);

        // Press held 20 frames: single strobe after edge 5.
        reset = 1'b0;
        bus_if._fireButton = 1'b0;
        first = -1;
        lows  = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus_if._isBulletFire == 1'b0) begin
                lows++;
                if (first < 0) first = k;
            end
        end
        chk("latency_edge", first, DB + 2);
        chk("single_strobe", lows, 1);
        chk("first_id", int'(bus_if.shootingBulletID), 0);
        chk("first_count", int'(bus_if.shotCount), 1);
        bus_if._fireButton = 1'b1;
        repeat (6) tick();

        // Two-frame glitch is rejected.
        do_reset();
        s0 = n_strobe;
        bus_if._fireButton = 1'b0;
        tick();
        tick();
        bus_if._fireButton = 1'b1;
        repeat (10) tick();
        chk("short_press_strobes", n_strobe - s0, 0);
        chk("short_press_count", int'(bus_if.shotCount), 0);

        // Round-robin wrap: fire slot 29, then 30/31/0 busy gives slot 1, then slot 2.
        do_reset();
        bus_if.bulletBusy = ~(32'h1 << 29);
        press();
        chk("rr_id29", int'(bus_if.shootingBulletID), 29);
        bus_if.bulletBusy = 32'hC000_0001;
        press();
        chk("rr_wrap_id", int'(bus_if.shootingBulletID), 1);
        bus_if.bulletBusy = 32'h0;
        press();
        chk("rr_next_id", int'(bus_if.shootingBulletID), 2);
        chk("rr_count", int'(bus_if.shotCount), 3);

        // All slots busy: one noFreeSlot pulse, no shot, re-press needed.
        s0 = n_strobe;
        f0 = n_nofree;
        bus_if.bulletBusy  = 32'hFFFF_FFFF;
        bus_if._fireButton = 1'b0;
        repeat (20) tick();
        bus_if.bulletBusy = 32'h0;
        repeat (10) tick();
        chk("full_nofree_pulses", n_nofree - f0, 1);
        chk("full_strobes", n_strobe - s0, 0);
        chk("full_count", int'(bus_if.shotCount), 3);
        chk("full_id_kept", int'(bus_if.shootingBulletID), 2);
        bus_if._fireButton = 1'b1;
        repeat (6) tick();
        press();
        chk("repress_strobes", n_strobe - s0, 1);
        chk("repress_id", int'(bus_if.shootingBulletID), 3);
        chk("repress_count", int'(bus_if.shotCount), 4);

        // Second press begun during cooldown is ignored until a fresh press.
        do_reset();
        s0 = n_strobe;
        bus_if._fireButton = 1'b0;
        repeat (7) tick();
        bus_if._fireButton = 1'b1;
        tick();
        bus_if._fireButton = 1'b0;
        repeat (30) tick();
        chk("cooldown_strobes", n_strobe - s0, 1);
        bus_if._fireButton = 1'b1;
        repeat (16) tick();
        press();
        chk("fresh_strobes", n_strobe - s0, 2);
        chk("fresh_gap_min", int'(fire_gap >= CD + DB + 2), 1);

        // gameActive dropped during debounce aborts the press.
        do_reset();
        s0 = n_strobe;
        bus_if._fireButton = 1'b0;
        repeat (3) tick();
        bus_if.gameActive  = 1'b0;
        bus_if._fireButton = 1'b1;
        repeat (10) tick();
        bus_if.gameActive = 1'b1;
        repeat (5) tick();
        chk("inactive_strobes", n_strobe - s0, 0);
        chk("inactive_count", int'(bus_if.shotCount), 0);

        // Reset during FIRE wins over the shot.
        press();
        chk("pre_rst_count", int'(bus_if.shotCount), 1);
        bus_if.bulletBusy  = ~(32'h1 << 7);
        bus_if._fireButton = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (bus_if._isBulletFire == 1'b0) seen = 1'b1;
        end
        chk("fire_reached", int'(seen), 1);
        chk("fire_id7", int'(bus_if.shootingBulletID), 7);
        reset = 1'b1;
        tick();
        chk("rstfire_strobe", int'(bus_if._isBulletFire), 1);
        chk("rstfire_id", int'(bus_if.shootingBulletID), 0);
        chk("rstfire_count", int'(bus_if.shotCount), 0);
        chk("rstfire_nofree", int'(bus_if.noFreeSlot), 0);
        reset = 1'b0;
        bus_if._fireButton = 1'b1;
        bus_if.bulletBusy  = 32'h0;
        s0 = n_strobe;
        repeat (6) tick();
        chk("rstfire_quiet", n_strobe - s0, 0);

        // Random traffic, checked every frame by the model.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(5) == 0)  bus_if._fireButton = ~bus_if._fireButton;
            if ($urandom_range(59) == 0) bus_if.gameActive  = ~bus_if.gameActive;
            case ($urandom_range(3))
                0:       bus_if.bulletBusy = 32'hFFFF_FFFF;
                1:       bus_if.bulletBusy = $urandom;
                default: bus_if.bulletBusy = $urandom | $urandom | $urandom;
            endcase
            reset = ($urandom_range(399) == 0);
            tick();
        end
        reset = 1'b0;

        // Shot counter saturates while slot selection keeps rotating.
        do_reset();
        for (int n = 0; n < 258; n++) press();
        chk("sat_count", int'(bus_if.shotCount), 255);
        chk("sat_id", int'(bus_if.shootingBulletID), 257 % 32);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
